// File: rtl/ctx_table.sv
// ctx_table: per-slot resume-PC table with a round-robin scheduler.
// Slot 0 belongs to the OS and is never granted; the scan visits one
// candidate per cycle starting after the last granted slot.
// Optional feature: define CTX_STATS_EN to add saturating 16-bit per-slot
// grant counters readable through stat_id / stat_count.
module ctx_table #(
  parameter int unsigned NPROG = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [IDW-1:0]   load_id,
  input  logic [31:0]      load_pc,
  input  logic             save_en,
  input  logic [IDW-1:0]   save_id,
  input  logic [31:0]      save_pc,
  input  logic             save_done,
  input  logic             sched_req,
  output logic             busy,
  output logic             sched_valid,
  output logic             sched_none,
  output logic [IDW-1:0]   sched_id,
  output logic [31:0]      sched_pc,
  output logic [NPROG-1:0] ready_mask
`ifdef CTX_STATS_EN
  ,
  input  logic [IDW-1:0]   stat_id,
  output logic [15:0]      stat_count
`endif
);

  localparam int unsigned PCW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  cand_q, cand_d;
  logic [IDW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic            busy_d, valid_d, none_d;
  logic [IDW-1:0]  id_d;
  logic [PCW-1:0]  pc_d;

  logic [PCW-1:0]  pc_q [NPROG];
  logic [NPROG-1:0] rdy_q;

  // Round-robin successor over slots 1..NPROG-1
  function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] x);
    if (x == IDW'(NPROG - 1)) return IDW'(1);
    else                      return x + IDW'(1);
  endfunction

  assign ready_mask = rdy_q;

  // Context table writes; load is applied last so it wins over a same-slot save
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(NPROG); i++) pc_q[i] <= '0;
      rdy_q <= '0;
    end else begin
      if (save_en && (save_id != '0)) begin
        pc_q[save_id]  <= save_pc;
        rdy_q[save_id] <= !save_done;
      end
      if (load_en && (load_id != '0)) begin
        pc_q[load_id]  <= load_pc;
        rdy_q[load_id] <= 1'b1;
      end
    end
  end

  // Scheduler state and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      busy        <= 1'b0;
      sched_valid <= 1'b0;
      sched_none  <= 1'b0;
      sched_id    <= '0;
      sched_pc    <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      busy        <= busy_d;
      sched_valid <= valid_d;
      sched_none  <= none_d;
      sched_id    <= id_d;
      sched_pc    <= pc_d;
    end
  end

  // Next-state logic; the response pulses are raised on entry to RESP
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    busy_d  = busy;
    valid_d = 1'b0;
    none_d  = 1'b0;
    id_d    = sched_id;
    pc_d    = sched_pc;
    unique case (state_q)
      ST_IDLE: begin
        if (sched_req) begin
          state_d = ST_SCAN;
          cand_d  = nxt(last_q);
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (cnt_q == IDW'(NPROG - 1)) begin
          state_d = ST_RESP;
          none_d  = 1'b1;
        end else if (rdy_q[cand_q]) begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          id_d    = cand_q;
          pc_d    = pc_q[cand_q];
          last_d  = cand_q;
        end else begin
          cand_d = nxt(cand_q);
          cnt_d  = cnt_q + IDW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef CTX_STATS_EN
  logic [15:0] gcnt_q [NPROG];

  // Saturating per-slot grant counters, bumped on each grant pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(NPROG); i++) gcnt_q[i] <= '0;
    end else if (sched_valid && (gcnt_q[sched_id] != 16'hFFFF)) begin
      gcnt_q[sched_id] <= gcnt_q[sched_id] + 16'd1;
    end
  end

  assign stat_count = gcnt_q[stat_id];
`endif

endmodule

// File: tb/tb_ctx_table.sv
// tb_ctx_table: directed plus randomized bench for ctx_table with a
// slot-array reference model of the round-robin scheduler.
module tb_ctx_table;

  localparam int NPROG = 4;
  localparam int IDW   = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             load_en, save_en, save_done, sched_req;
  logic [IDW-1:0]   load_id, save_id;
  logic [31:0]      load_pc, save_pc;
  logic             busy, sched_valid, sched_none;
  logic [IDW-1:0]   sched_id;
  logic [31:0]      sched_pc;
  logic [NPROG-1:0] ready_mask;
  logic [IDW-1:0]   stat_id;
  logic [15:0]      stat_count;

  ctx_table #(.NPROG(NPROG), .IDW(IDW)) dut (
    .clock(clock), .reset(reset),
    .load_en(load_en), .load_id(load_id), .load_pc(load_pc),
    .save_en(save_en), .save_id(save_id), .save_pc(save_pc), .save_done(save_done),
    .sched_req(sched_req), .busy(busy), .sched_valid(sched_valid),
    .sched_none(sched_none), .sched_id(sched_id), .sched_pc(sched_pc),
    .ready_mask(ready_mask)
`ifdef CTX_STATS_EN
    , .stat_id(stat_id), .stat_count(stat_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: slot contents, last grant, held response, grant counts
  logic [31:0] m_pc  [NPROG];
  bit          m_rdy [NPROG];
  int          m_last;
  int          m_id;
  logic [31:0] m_pc_out;
  int          m_cnt [NPROG];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int nxtm(input int x);
    return (x == NPROG - 1) ? 1 : x + 1;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    for (int i = 1; i < NPROG; i++) m[i] = m_rdy[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NPROG; i++) begin
      m_pc[i] = '0; m_rdy[i] = 0; m_cnt[i] = 0;
    end
    m_last = 0; m_id = 0; m_pc_out = '0;
  endtask

  task automatic check_stats(input string tag);
`ifdef CTX_STATS_EN
    for (int i = 0; i < NPROG; i++) begin
      stat_id = IDW'(i);
      #0;
      chk(tag, 32'(stat_count), 32'(m_cnt[i]));
    end
`else
    stat_id = '0;
`endif
  endtask

  // One write cycle (save and/or load), then model update and mask check
  task automatic wr(input bit le, input int lid, input logic [31:0] lpc,
                    input bit se, input int sid, input logic [31:0] spc, input bit sd);
    load_en = le; load_id = IDW'(lid); load_pc = lpc;
    save_en = se; save_id = IDW'(sid); save_pc = spc; save_done = sd;
    tick();
    load_en = 0; save_en = 0; save_done = 0;
    if (se && sid != 0) begin m_pc[sid] = spc; m_rdy[sid] = !sd; end
    if (le && lid != 0) begin m_pc[lid] = lpc; m_rdy[lid] = 1; end
    chk("ready_mask", 32'(ready_mask), model_mask());
  endtask

  // One scheduling request; hold keeps sched_req high while busy
  task automatic req(input bit hold);
    int found, k, c, lat, exp_lat;
    found = -1; k = 0; c = nxtm(m_last);
    for (int i = 0; i < NPROG - 1; i++) begin
      if (m_rdy[c]) begin found = c; k = i; break; end
      c = nxtm(c);
    end
    exp_lat = (found >= 0) ? k + 2 : NPROG + 1;
    sched_req = 1;
    tick();
    if (!hold) sched_req = 0;
    chk("busy_start", 32'(busy), 32'd1);
    lat = 1;
    while (!(sched_valid || sched_none) && lat < 20) begin
      tick();
      lat++;
    end
    sched_req = 0;
    if (found >= 0) begin
      m_id = found; m_pc_out = m_pc[found]; m_last = found; m_cnt[found]++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("pulse_kind", {30'd0, sched_valid, sched_none}, (found >= 0) ? 32'd2 : 32'd1);
    chk("busy_resp", 32'(busy), 32'd1);
    chk("sched_id", 32'(sched_id), 32'(m_id));
    chk("sched_pc", sched_pc, m_pc_out);
    tick();
    chk("after_resp", {29'd0, busy, sched_valid, sched_none}, 32'd0);
    chk("id_hold", 32'(sched_id), 32'(m_id));
  endtask

  initial begin
    reset = 0; load_en = 0; save_en = 0; save_done = 0; sched_req = 0;
    load_id = '0; save_id = '0; load_pc = '0; save_pc = '0; stat_id = '0;
    model_reset();
    tick(); tick();
    chk("rst_outs", {29'd0, busy, sched_valid, sched_none}, 32'd0);
    chk("rst_id", 32'(sched_id), 32'd0);
    chk("rst_pc", sched_pc, 32'd0);
    chk("rst_mask", 32'(ready_mask), 32'd0);
    check_stats("rst_stat");
    reset = 1;
    tick();

    // Empty table: no-ready result
    req(0);
    // Two loaded slots granted in order
    wr(1, 1, 32'h10, 0, 0, 0, 0);
    wr(1, 3, 32'h30, 0, 0, 0, 0);
    req(0);
    chk("tp_id1", 32'(sched_id), 32'd1);
    req(0);
    chk("tp_pc3", sched_pc, 32'h30);
    // Resume PC update
    wr(0, 0, 0, 1, 3, 32'h35, 0);
    req(0);
    req(0);
    chk("tp_pc35", sched_pc, 32'h35);
    // Program end clears ready
    wr(0, 0, 0, 1, 1, 32'h44, 1);
    chk("tp_mask8", 32'(ready_mask), 32'h8);
    req(0);
    req(0);
    chk("tp_id3", 32'(sched_id), 32'd3);
    // Same-cycle load and save: load wins; request held while busy
    wr(1, 2, 32'h20, 1, 2, 32'h99, 1);
    req(1);
    chk("tp_pc20", sched_pc, 32'h20);
    // Save to slot 0 is ignored
    wr(0, 0, 0, 1, 0, 32'hdead, 0);
    check_stats("stat_dir");

    // Reset in the middle of a scan aborts without a pulse
    wr(0, 0, 0, 1, 2, 32'h22, 1);
    wr(0, 0, 0, 1, 3, 32'h33, 1);
    sched_req = 1;
    tick();
    sched_req = 0;
    tick();
    reset = 0;
    tick();
    model_reset();
    chk("abort_outs", {29'd0, busy, sched_valid, sched_none}, 32'd0);
    chk("abort_id", 32'(sched_id), 32'd0);
    chk("abort_mask", 32'(ready_mask), 32'd0);
    reset = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_quiet", {30'd0, sched_valid, sched_none}, 32'd0);
    end
    check_stats("abort_stat");

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) < 2)
        wr(1'($urandom_range(0, 1)), int'($urandom_range(0, NPROG - 1)), $urandom,
           1'($urandom_range(0, 1)), int'($urandom_range(0, NPROG - 1)), $urandom,
           1'($urandom_range(0, 1)));
      else
        req(1'($urandom_range(0, 1)));
    end
    check_stats("stat_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctx_table.md
# ctx_table

Process-context table and round-robin scheduler for the multiprogrammed processor. It stores the resume PC of every program slot and accepts saves from the PC unit on each context switch. When asked, it scans for the next ready slot and returns that slot's id and resume PC. The PC unit consumes the returned PC as its program-counter load address and the returned id as its program number.

## Interface
- `NPROG`, default 4: number of program slots. Must be at least 2. Slot 0 is the OS and is never granted.
- `IDW`, default 2: slot-id width, equal to $clog2(NPROG).
- `clock  in  1`: clock, rising edge.
- `reset  in  1`: synchronous, active-low.
- `load_en  in  1`: initialise slot `load_id`. Sets PC to `load_pc` and marks the slot ready.
- `load_id  in  IDW`: slot to initialise.
- `load_pc  in  32`: program start address, relative to the program.
- `save_en  in  1`: store `save_pc` into slot `save_id`.
- `save_id  in  IDW`: slot being switched out.
- `save_pc  in  32`: resume address.
- `save_done  in  1`: qualifies `save_en`. The program ended, so the slot is cleared to not-ready.
- `sched_req  in  1`: request the next program. Sampled only while `busy` = 0.
- `busy  out  1`: scan in progress.
- `sched_valid  out  1`: one-cycle pulse. `sched_id` and `sched_pc` are valid this cycle.
- `sched_none  out  1`: one-cycle pulse. No slot is ready.
- `sched_id  out  IDW`: granted slot.
- `sched_pc  out  32`: resume PC of the granted slot.
- `ready_mask  out  NPROG`: per-slot ready bits. Bit 0 is always 0.

## Operation
- State per slot: `pc[i]` (32 bits) and `rdy[i]`.
- Last-granted pointer `last`: IDW bits, reset value 0.
- FSM has three states: IDLE, SCAN, RESP.
  - IDLE, with `sched_req` = 1: go to SCAN. Set candidate `cand` = next(last). `busy` goes high.
  - SCAN: one slot is examined per cycle.
    - If `rdy[cand]` = 1: latch `sched_id` = cand and `sched_pc` = pc[cand]. Set `last` = cand and go to RESP.
    - Otherwise advance `cand` to next(cand).
    - If NPROG−1 candidates have been examined without a hit, go to RESP with the none flag set.
  - RESP: pulse `sched_valid`, or `sched_none` if the none flag is set. Return to IDLE.
- next(x): x+1, wrapping from NPROG−1 to 1. Slot 0 is skipped.
- Save write:
  - `save_en` & `save_id` ≠ 0: `pc[save_id]` ← `save_pc`.
  - `rdy[save_id]` ← !`save_done`.
  - `save_id` = 0 is ignored.
- Load write:
  - `load_en` & `load_id` ≠ 0: `pc[load_id]` ← `load_pc` and `rdy` ← 1.
  - Load overrides a save to the same slot in the same cycle.
- SCAN reads the registered `rdy` and `pc`. A write in cycle t is visible to a candidate check from cycle t+1.
- `sched_pc` and `sched_id` hold their last granted values until the next grant.
- `sched_req` while `busy` = 1 is ignored. No queueing.

## Timing
- Reset values:
  - All `pc` = 0, all `rdy` = 0, `last` = 0, state IDLE.
  - `busy`, `sched_valid`, `sched_none`, `sched_id`, `sched_pc` = 0.
  - `ready_mask` = 0.
- Reset mid-scan aborts the scan. No pulse is issued.
- Latency from `sched_req` to the `sched_valid` pulse is k+2 cycles, where k (0..NPROG−2) is the hit's distance from next(last).
- A no-ready result pulses `sched_none` at NPROG+1 cycles.
- `busy` is high from the cycle after the `sched_req` edge through the RESP cycle inclusive.

## Configuration
- `CTX_STATS_EN` defined: adds a 16-bit per-slot grant counter.
  - The counter increments on each `sched_valid` for that slot and saturates at 0xFFFF.
  - Read via inputs `stat_id` (IDW) and output `stat_count` (16). The read is combinational.
  - Counters are zeroed by reset.
- `CTX_STATS_EN` undefined: the counters and the `stat_*` ports are absent.

## Test plan
- Reset, then `sched_req` → `sched_none` at cycle 5 (NPROG=4), `sched_id` = 0, `sched_pc` = 0.
- Load slot 1 with 0x10 and slot 3 with 0x30. Pulse `sched_req` → grant id 1, pc 0x10 (k=0, latency 2). Request again → id 3, pc 0x30, latency 3.
- `save_en`, id 3, pc 0x35, done 0. Then `sched_req` → id 1. Then `sched_req` → id 3 with pc 0x35.
- `save_en`, id 1, done 1 → `ready_mask` = 4'b1000. The next two requests both grant id 3.
- Same-cycle load and save to slot 2 (load 0x20, save 0x99, done 1) → `pc[2]` = 0x20, ready. `sched_req` asserted while busy → no extra grant.
- `CTX_STATS_EN`: three grants of slot 3 → `stat_count` = 3 for `stat_id` = 3. Reset mid-SCAN → no pulse and all counters 0.
